// File: rtl/rowcol_operand_sequencer.sv
// ---------------------------------------------------------------------------
// rowcol_operand_sequencer
//
// Feeder and collector wrapped around an external combinational (or
// single-register) dot-product unit that computes one element of the
// SIZE x SIZE matrix product C = A*B per presentation.
//
// Flow: A then B arrive row-major as a word stream and are stored locally.
// For each result C[i][j] the sequencer registers row i of A and column j
// of B onto row_vec/col_vec, samples the scalar dot_y a fixed number of
// cycles later, and hands the result downstream over valid/ready. Results
// leave in row-major order; the final one carries out_last.
//
// Optional build macro:
//   DOT_PIPE_EN  inserts a WAIT state between PRESENT and CAPTURE so dot_y
//                is sampled two cycles after the vectors change (for a dot
//                unit with a 1-cycle output register). Undefined by default.
//
// Parameters:
//   WIDTH  element and result word length
//   SIZE   matrix dimension, power of 2
//
// Ports:
//   CLK        clock, all state changes on posedge
//   RST        synchronous active-high reset
//   start      begin a new load (honoured only when idle)
//   in_data    operand word
//   in_valid   in_data valid
//   in_ready   sequencer accepts in_data (LOAD_A / LOAD_B only)
//   row_vec    packed row i of A, element k at [WIDTH*(k+1)-1:WIDTH*k]
//   col_vec    packed column j of B, same packing
//   dot_y      dot product of row_vec and col_vec from the external unit
//   out_data   result element C[i][j]
//   out_valid  out_data valid
//   out_ready  downstream accepts out_data
//   out_last   high with the C[SIZE-1][SIZE-1] beat
//   busy       high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module rowcol_operand_sequencer #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH*SIZE-1:0] row_vec,
  output logic [WIDTH*SIZE-1:0] col_vec,
  input  logic [WIDTH-1:0]      dot_y,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy
);

  localparam int NELEM = SIZE * SIZE;
  // Keep counters at least one bit wide so SIZE=1 still elaborates.
  localparam int CW = (NELEM > 1) ? $clog2(NELEM) : 1;
  localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(NELEM - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(SIZE - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_A  = 3'd1;
  localparam logic [2:0] S_LOAD_B  = 3'd2;
  localparam logic [2:0] S_PRESENT = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_CAPTURE = 3'd5;
  localparam logic [2:0] S_HOLD    = 3'd6;

  // Flat row-major element index of (r, c).
  function automatic logic [CW-1:0] elem_idx(input logic [IW-1:0] r,
                                             input logic [IW-1:0] c);
    return CW'(int'(r) * SIZE + int'(c));
  endfunction

  // Operand storage; never reset, contents are don't-care until reloaded.
  logic [WIDTH-1:0] a_mem [NELEM];
  logic [WIDTH-1:0] b_mem [NELEM];

  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         i_q, i_d;
  logic [IW-1:0]         j_q, j_d;
  logic                  in_ready_q, in_ready_d;
  logic [WIDTH*SIZE-1:0] row_vec_q, row_vec_d;
  logic [WIDTH*SIZE-1:0] col_vec_q, col_vec_d;
  logic [WIDTH-1:0]      out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic                  busy_q, busy_d;

  logic                  in_fire_s;
  logic                  out_fire_s;
  logic                  is_last_s;
  logic [WIDTH*SIZE-1:0] row_sel_s;
  logic [WIDTH*SIZE-1:0] col_sel_s;

  // in_ready_q is high exactly in the two load states, so it doubles as
  // the load-state qualifier for accepted beats.
  assign in_fire_s  = in_valid & in_ready_q;
  assign out_fire_s = out_valid_q & out_ready;
  assign is_last_s  = (i_q == IDX_LAST) && (j_q == IDX_LAST);

  // Gather row i of A and column j of B from storage.
  always_comb begin
    row_sel_s = '0;
    col_sel_s = '0;
    for (int k = 0; k < SIZE; k++) begin
      row_sel_s[k*WIDTH +: WIDTH] = a_mem[elem_idx(i_q, IW'(k))];
      col_sel_s[k*WIDTH +: WIDTH] = b_mem[elem_idx(IW'(k), j_q)];
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    i_d         = i_q;
    j_d         = j_q;
    row_vec_d   = row_vec_q;
    col_vec_d   = col_vec_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD_A;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_LOAD_A: begin
        if (in_fire_s) begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_LOAD_B;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + CW'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end

      S_LOAD_B: begin
        if (in_fire_s) begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_PRESENT;
            cnt_d   = '0;
            i_d     = '0;
            j_d     = '0;
          end else begin
            cnt_d   = cnt_q + CW'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end

      S_PRESENT: begin
        row_vec_d = row_sel_s;
        col_vec_d = col_sel_s;
`ifdef DOT_PIPE_EN
        state_d   = S_WAIT;
`else
        state_d   = S_CAPTURE;
`endif
      end

      // Gives a registered dot unit one extra cycle to settle.
      S_WAIT: begin
        state_d = S_CAPTURE;
      end

      S_CAPTURE: begin
        out_data_d  = dot_y;
        out_valid_d = 1'b1;
        out_last_d  = is_last_s;
        state_d     = S_HOLD;
      end

      S_HOLD: begin
        if (out_fire_s) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_last_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_PRESENT;
            if (j_q == IDX_LAST) begin
              j_d = '0;
              i_d = i_q + IW'(1);
            end else begin
              j_d = j_q + IW'(1);
            end
          end
        end else begin
          state_d = S_HOLD;
        end
      end

      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase

    // Status flags follow the state being entered so they are registered
    // yet aligned with the state register.
    in_ready_d = (state_d == S_LOAD_A) || (state_d == S_LOAD_B);
    busy_d     = (state_d != S_IDLE);
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      in_ready_q  <= 1'b0;
      row_vec_q   <= '0;
      col_vec_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      i_q         <= i_d;
      j_q         <= j_d;
      in_ready_q  <= in_ready_d;
      row_vec_q   <= row_vec_d;
      col_vec_q   <= col_vec_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end

  // Operand storage writes; reset wins over a beat in the same cycle.
  always_ff @(posedge CLK) begin
    if (!RST && in_fire_s) begin
      if (state_q == S_LOAD_A) begin
        a_mem[cnt_q] <= in_data;
      end else begin
        b_mem[cnt_q] <= in_data;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign row_vec   = row_vec_q;
  assign col_vec   = col_vec_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_rowcol_operand_sequencer.sv
// ---------------------------------------------------------------------------
// Bench for rowcol_operand_sequencer with SIZE=2, WIDTH=32.
// The external dot-product unit is an integer stub (registered when
// DOT_PIPE_EN is defined). Expected results come from a plain matrix
// multiply over the operand arrays.
// ---------------------------------------------------------------------------
module tb_rowcol_operand_sequencer;

  localparam int W = 32;
  localparam int N = 2;
`ifdef DOT_PIPE_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic           CLK = 1'b0;
  logic           RST;
  logic           start;
  logic [W-1:0]   in_data;
  logic           in_valid;
  logic           in_ready;
  logic [W*N-1:0] row_vec;
  logic [W*N-1:0] col_vec;
  logic [W-1:0]   dot_y;
  logic [W-1:0]   dot_comb;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic           out_last;
  logic           busy;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int beat_cyc   = 0;

  logic [W-1:0] a_m   [4];
  logic [W-1:0] b_m   [4];
  logic [W-1:0] exp_c [4];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  rowcol_operand_sequencer #(.WIDTH(W), .SIZE(N)) dut (
    .CLK(CLK), .RST(RST), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .row_vec(row_vec), .col_vec(col_vec), .dot_y(dot_y),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy)
  );

  // Dot-product stub.
  always_comb begin
    dot_comb = '0;
    for (int k = 0; k < N; k++)
      dot_comb = dot_comb + row_vec[k*W +: W] * col_vec[k*W +: W];
  end
`ifdef DOT_PIPE_EN
  always @(posedge CLK) dot_y <= dot_comb;
`else
  assign dot_y = dot_comb;
`endif

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: C = A*B, modulo 2^32.
  task automatic model();
    logic [W-1:0] s;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = '0;
        for (int k = 0; k < N; k++) s = s + a_m[i*N+k] * b_m[k*N+j];
        exp_c[i*N+j] = s;
      end
  endtask

  task automatic set_t1();
    a_m[0] = 32'd1; a_m[1] = 32'd2; a_m[2] = 32'd3; a_m[3] = 32'd4;
    b_m[0] = 32'd5; b_m[1] = 32'd6; b_m[2] = 32'd7; b_m[3] = 32'd8;
    model();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", 128'(busy), 128'(1'b1));
    chk("in_ready_after_start", 128'(in_ready), 128'(1'b1));
  endtask

  // gap: 0 none, 1 one idle cycle after each word, 2 random 0..2 idle cycles.
  // start_at: word index at which a stray start pulse is applied (-1 none).
  task automatic load_mats(input int gap, input int start_at);
    int ng;
    for (int w = 0; w < 2*N*N; w++) begin
      in_data  = (w < N*N) ? a_m[w] : b_m[w-N*N];
      in_valid = 1'b1;
      if (w == start_at) start = 1'b1;
      chk("in_ready_load", 128'(in_ready), 128'(1'b1));
      tick();
      start    = 1'b0;
      in_valid = 1'b0;
      if (w == 2*N*N-1) begin
        beat_cyc = cyc;
      end else begin
        ng = (gap == 1) ? 1 : ((gap == 2) ? int'($urandom_range(0, 2)) : 0);
        for (int g = 0; g < ng; g++) begin
          in_data = $urandom;
          tick();
        end
      end
    end
    chk("in_ready_after_load", 128'(in_ready), 128'(1'b0));
  endtask

  // stall: 0 out_ready held high, 1 five stall cycles, 2 random 0..3.
  task automatic collect(input int stall);
    int last_edge;
    int guard;
    int ns;
    last_edge = beat_cyc;
    out_ready = (stall == 0);
    for (int idx = 0; idx < N*N; idx++) begin
      guard = 0;
      while (!out_valid && guard < 20) begin
        tick();
        guard++;
      end
      chk("out_valid_rise", 128'(out_valid), 128'(1'b1));
      chk("latency", 128'(cyc - last_edge + 1), 128'(LAT));
      chk("out_data", 128'(out_data), 128'(exp_c[idx]));
      chk("out_last", 128'(out_last), 128'(idx == N*N-1));
      chk("busy_run", 128'(busy), 128'(1'b1));
      chk("row_vec", 128'(row_vec), 128'({a_m[(idx/N)*N+1], a_m[(idx/N)*N]}));
      chk("col_vec", 128'(col_vec), 128'({b_m[N + idx%N], b_m[idx%N]}));
      ns = (stall == 1) ? 5 : ((stall == 2) ? int'($urandom_range(0, 3)) : 0);
      for (int s = 0; s < ns; s++) begin
        tick();
        chk("stall_valid", 128'(out_valid), 128'(1'b1));
        chk("stall_data", 128'(out_data), 128'(exp_c[idx]));
      end
      out_ready = 1'b1;
      tick();
      last_edge = cyc;
      if (stall != 0) out_ready = 1'b0;
      chk("valid_after_accept", 128'(out_valid), 128'(1'b0));
    end
    chk("busy_end", 128'(busy), 128'(1'b0));
    chk("out_last_end", 128'(out_last), 128'(1'b0));
    out_ready = 1'b0;
  endtask

  initial begin
    int guard;
    RST = 1'b1; start = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    RST = 1'b0;
    tick();
    chk("rst_in_ready", 128'(in_ready), 128'(1'b0));
    chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
    chk("rst_out_last", 128'(out_last), 128'(1'b0));
    chk("rst_busy", 128'(busy), 128'(1'b0));
    chk("rst_row_vec", 128'(row_vec), 128'(0));
    chk("rst_col_vec", 128'(col_vec), 128'(0));
    chk("rst_out_data", 128'(out_data), 128'(0));

    // T1 basic
    set_t1();
    do_start();
    load_mats(0, -1);
    collect(0);

    // T2 backpressure
    do_start();
    load_mats(0, -1);
    collect(1);

    // T3 input gaps
    do_start();
    load_mats(1, -1);
    collect(0);

    // T5 in_valid while idle, then stray start during LOAD_B
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    repeat (3) begin
      tick();
      chk("idle_in_ready", 128'(in_ready), 128'(1'b0));
      chk("idle_busy", 128'(busy), 128'(1'b0));
    end
    in_valid = 1'b0;
    do_start();
    load_mats(0, 5);
    collect(0);

    // T4 reset while holding 22
    do_start();
    load_mats(0, -1);
    out_ready = 1'b0;
    guard = 0;
    while (!out_valid && guard < 20) begin tick(); guard++; end
    chk("t4_first", 128'(out_data), 128'(exp_c[0]));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    guard = 0;
    while (!out_valid && guard < 20) begin tick(); guard++; end
    chk("t4_hold_22", 128'(out_data), 128'(32'd22));
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("t4_out_valid", 128'(out_valid), 128'(1'b0));
    chk("t4_busy", 128'(busy), 128'(1'b0));
    chk("t4_row_vec", 128'(row_vec), 128'(0));
    chk("t4_col_vec", 128'(col_vec), 128'(0));
    chk("t4_out_data", 128'(out_data), 128'(0));
    chk("t4_in_ready", 128'(in_ready), 128'(1'b0));
    a_m[0] = 32'd1; a_m[1] = 32'd0; a_m[2] = 32'd0; a_m[3] = 32'd1;
    b_m[0] = 32'd9; b_m[1] = 32'd8; b_m[2] = 32'd7; b_m[3] = 32'd6;
    model();
    do_start();
    load_mats(0, -1);
    collect(0);

    // Randomized runs
    for (int r = 0; r < 8; r++) begin
      for (int e = 0; e < 4; e++) begin
        a_m[e] = $urandom;
        b_m[e] = $urandom;
      end
      model();
      do_start();
      load_mats(2, -1);
      collect(2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
